alu_issue_ctrl: RTL and testbench

- Issue/retire stage wrapped around the ALU. It sits upstream of the ALU, driving its operands, and downstream of it, capturing its result.
- Accepts one operation over a valid/ready handshake and drives A/B/OP to the ALU, holding them stable.
- Waits the operation-dependent latency, then captures S/Carry_out and presents them on an output valid/ready handshake.
- Replaces fixed-delay sequencing with a latency-accurate hardware controller.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_latency_calc.sv | 24 ++
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default operand width for the ALU issue/retire slice.
package alu_pkg;

    localparam int ALU_N = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] MUL_OP = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_latency_calc.sv
// Combinational ALU latency: 1 for plain ops, (bit length of |B|) + 1 for the multiply.
module alu_latency_calc #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 2)
) (
    input  logic [N-1:0]     b,
    input  logic             is_mul,
    output logic [CNT_W-1:0] w
);

    logic [N-1:0]     mag;
    logic [CNT_W-1:0] lead;

    always_comb begin
        // -2^(N-1) negates to itself, which read unsigned is exactly 2^(N-1)
        mag  = b[N-1] ? (~b + {{(N-1){1'b0}}, 1'b1}) : b;
        lead = '0;
        for (int i = 0; i < N; i++) begin
            if (mag[i]) lead = CNT_W'(i + 1);
        end
        w = is_mul ? (lead + {{(CNT_W-1){1'b0}}, 1'b1}) : CNT_W'(1);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller around the ALU: holds operands for the op's latency, then captures the result.
// Optional STAT_OPS/STAT_CYCLES counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int         N      = ALU_N,
    parameter logic [3:0] MUL_OP = alu_pkg::MUL_OP,
    parameter int         CNT_W  = $clog2(N + 2)
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [N-1:0]   IN_A,
    input  logic [N-1:0]   IN_B,
    input  logic [3:0]     IN_OP,
    output logic [N-1:0]   ALU_A,
    output logic [N-1:0]   ALU_B,
    output logic [3:0]     ALU_OP,
    input  logic [2*N-1:0] ALU_S,
    input  logic           ALU_CARRY,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*N-1:0] OUT_S,
    output logic           OUT_CARRY,
    output logic [3:0]     OUT_OP,
    output logic           BUSY
`ifdef ALU_ISSUE_STATS_EN
   ,output logic [15:0]    STAT_OPS
   ,output logic [31:0]    STAT_CYCLES
`endif
);

    logic rst_meta_q, rst_sync_q;

    // Assert asynchronously, release two edges after RESET_N rises
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [2*N-1:0]   out_s_q, out_s_d;
    logic             out_carry_q, out_carry_d;
    logic [3:0]       out_op_q, out_op_d;
    logic [CNT_W-1:0] lat_w;

    alu_latency_calc #(.N(N), .CNT_W(CNT_W)) u_lat (
        .b      (IN_B),
        .is_mul (IN_OP == MUL_OP),
        .w      (lat_w)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        out_s_d     = out_s_q;
        out_carry_d = out_carry_q;
        out_op_d    = out_op_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    alu_a_d  = IN_A;
                    alu_b_d  = IN_B;
                    alu_op_d = IN_OP;
                    cnt_d    = lat_w;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    out_s_d     = ALU_S;
                    out_carry_d = ALU_CARRY;
                    out_op_d    = alu_op_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            out_s_q     <= '0;
            out_carry_q <= 1'b0;
            out_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_s_q     <= out_s_d;
            out_carry_q <= out_carry_d;
            out_op_q    <= out_op_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_OP    = alu_op_q;
    assign OUT_S     = out_s_q;
    assign OUT_CARRY = out_carry_q;
    assign OUT_OP    = out_op_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_cycles_q, stat_cycles_d;

    always_comb begin
        stat_ops_d    = stat_ops_q;
        stat_cycles_d = stat_cycles_q;
        if (OUT_VALID && OUT_READY && (stat_ops_q != '1))
            stat_ops_d = stat_ops_q + 16'd1;
        if ((state_q == WAIT) && (stat_cycles_q != '1))
            stat_cycles_d = stat_cycles_q + 32'd1;
    end

    always_ff @(posedge CLOCK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            stat_ops_q    <= '0;
            stat_cycles_q <= '0;
        end else begin
            stat_ops_q    <= stat_ops_d;
            stat_cycles_q <= stat_cycles_d;
        end
    end

    assign STAT_OPS    = stat_ops_q;
    assign STAT_CYCLES = stat_cycles_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl; the bench plays the ALU and predicts results and latencies.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [N-1:0]  in_a = '0, in_b = '0;
    logic [3:0]    in_op = '0;
    logic [N-1:0]  alu_a, alu_b;
    logic [3:0]    alu_op;
    logic [2*N-1:0] alu_s;
    logic          alu_c;
    logic          out_valid, out_ready = 1'b0;
    logic [2*N-1:0] out_s;
    logic          out_carry;
    logic [3:0]    out_op;
    logic          busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]   stat_ops;
    logic [31:0]   stat_cycles;
`endif

    logic [N-1:0]  lc_b = '0;
    logic          lc_mul = 1'b0;
    logic [3:0]    lc_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .CLOCK(clk), .RESET_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_A(in_a), .IN_B(in_b), .IN_OP(in_op),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op),
        .ALU_S(alu_s), .ALU_CARRY(alu_c),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_S(out_s), .OUT_CARRY(out_carry), .OUT_OP(out_op),
        .BUSY(busy)
`ifdef ALU_ISSUE_STATS_EN
       ,.STAT_OPS(stat_ops), .STAT_CYCLES(stat_cycles)
`endif
    );

    alu_latency_calc #(.N(N), .CNT_W(4)) u_lc (.b(lc_b), .is_mul(lc_mul), .w(lc_w));

    // Integer-arithmetic behaviour of the ALU the bench stands in for
    task automatic ref_alu(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                           output logic [2*N-1:0] s, output logic c);
        int ia, ib, r;
        ia = $signed(a);
        ib = $signed(b);
        c  = 1'b0;
        if (op == MUL_OP) begin
            r = ia * ib;
            s = r[2*N-1:0];
        end else if (op == OP_ADD) begin
            r = int'(a) + int'(b);
            s = {8'd0, r[7:0]};
            c = (r >= 256);
        end else begin
            s = {a, a ^ b};
        end
    endtask

    always_comb ref_alu(alu_a, alu_b, alu_op, alu_s, alu_c);

    function automatic int ref_lat(input logic [N-1:0] b, input bit is_mul);
        int v, l;
        if (!is_mul) return 1;
        v = $signed(b);
        if (v < 0) v = -v;
        l = 0;
        while (v > 0) begin
            l++;
            v = v / 2;
        end
        return l + 1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op, input int bp);
        int w, n;
        bit got;
        logic [2*N-1:0] es;
        logic ec;
        w = ref_lat(b, op == MUL_OP);
        ref_alu(a, b, op, es, ec);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: IN_READY=%b required 1", in_ready);
            return;
        end
        out_ready = (bp == 0);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = N'($urandom); in_b = N'($urandom); in_op = 4'($urandom);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_state: IN_READY=%b BUSY=%b required 0/1", in_ready, busy);
        end
        n = 0; got = 0;
        while (n < 20) begin
            checks++;
            if (alu_a !== a || alu_b !== b || alu_op !== op) begin
                errors++;
                $display("FAIL alu_hold: A=%h B=%h OP=%h required %h %h %h", alu_a, alu_b, alu_op, a, b, op);
            end
            @(posedge clk); #1; n++;
            if (out_valid === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got || n != w) begin
            errors++;
            $display("FAIL latency: op=%h b=%h got %0d cycles (seen=%0d) required %0d", op, b, n, got, w);
        end
        checks++;
        if (out_s !== es || out_carry !== ec || out_op !== op) begin
            errors++;
            $display("FAIL result: S=%h C=%b OP=%h required %h %b %h", out_s, out_carry, out_op, es, ec, op);
        end
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; in_a = N'($urandom); in_b = N'($urandom); in_op = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_s !== es || out_carry !== ec || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: V=%b S=%h C=%b IR=%b required 1 %h %b 0", out_valid, out_s, out_carry, in_ready, es, ec);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retire: V=%b IR=%b BUSY=%b required 0 1 0", out_valid, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_s !== '0 ||
            out_carry !== 1'b0 || out_op !== '0 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
            errors++;
            $display("FAIL reset_values: IR=%b V=%b BUSY=%b S=%h A=%h B=%h required 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_s, alu_a, alu_b);
        end
        apply_reset();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: IR=%b BUSY=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        do_op(8'd5, 8'd3, OP_ADD, 0);
        do_op(8'd5, 8'd3, MUL_OP, 0);
        do_op(8'd7, 8'd0, MUL_OP, 0);
        do_op(8'd3, 8'h80, MUL_OP, 0);
        do_op(8'h85, 8'hFF, MUL_OP, 0);
        do_op(8'hF0, 8'h20, OP_ADD, 0);
    endtask

    task automatic test_latency_calc();
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                lc_b = 8'(v); lc_mul = (m == 1);
                #1;
                checks++;
                if (int'(lc_w) != ref_lat(lc_b, lc_mul)) begin
                    errors++;
                    $display("FAIL latency_calc: b=%h mul=%b w=%0d required %0d", lc_b, lc_mul, lc_w, ref_lat(lc_b, lc_mul));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_op(8'd9, 8'd6, MUL_OP, 5);
        do_op(8'hC3, 8'h5A, OP_XOR, 5);
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; in_a = 8'd11; in_b = 8'h80; in_op = MUL_OP;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_s !== '0 || alu_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: IR=%b V=%b BUSY=%b S=%h B=%h required 1 0 0 0 0", in_ready, out_valid, busy, out_s, alu_b);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_valid: OUT_VALID=%b required 0", out_valid);
            end
        end
        do_op(8'd4, 8'hFD, MUL_OP, 1);
    endtask

    task automatic test_random();
        logic [3:0] ops [3];
        ops[0] = OP_ADD; ops[1] = OP_XOR; ops[2] = MUL_OP;
        for (int i = 0; i < 30; i++)
            do_op(N'($urandom), N'($urandom), ops[$urandom_range(2, 0)], int'($urandom_range(3, 0)));
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats();
        apply_reset();
        do_op(8'd5, 8'd3, OP_ADD, 0);
        do_op(8'd5, 8'd3, MUL_OP, 2);
        do_op(8'd1, 8'h80, MUL_OP, 0);
        checks++;
        if (stat_ops !== 16'd3 || stat_cycles !== 32'd13) begin
            errors++;
            $display("FAIL stats: ops=%0d cycles=%0d required 3 13", stat_ops, stat_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency_calc();
        test_basic();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
`ifdef ALU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
